// File: rtl/fifo_check_arbiter.sv
// ============================================================================
// fifo_check_arbiter : round-robin arbiter for the line-buffer FIFO check port
// Revision 1.0
// ============================================================================
`default_nettype none

module fifo_check_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TO_WIDTH       = 7
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic                          done_o,
   output logic                          hit_o,
   output logic                          busy_o,
   output logic                          timeout_err_o,
   input  logic                          ff_empty_i,
   output logic                          ff_check_req_o,
   output logic [DATA_WIDTH-1:0]         ff_check_dat_o,
   input  logic                          ff_check_res_i,
   input  logic                          ff_check_vld_i
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_REQ-1:0]    gnt_q, gnt_d;
   logic                  hit_q, hit_d;
   logic                  terr_q, terr_d;
   logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]      last_q, last_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;

   logic [DATA_WIDTH-1:0] w_dat [NUM_REQ];
   logic                  w_win_vld;
   logic [IDX_W-1:0]      w_win_idx;

   generate
      for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
         assign w_dat[g] = req_dat_i[g*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Search upward from the requester after the last winner, wrapping once.
   always_comb begin
      int k;
      w_win_vld = 1'b0;
      w_win_idx = '0;
      k         = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = (int'(last_q) + 1 + i) % NUM_REQ;
         if (!w_win_vld && req_i[IDX_W'(k)]) begin
            w_win_vld = 1'b1;
            w_win_idx = IDX_W'(k);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      hit_d   = hit_q;
      terr_d  = terr_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      dat_d   = dat_q;
      case (state_q)
         S_IDLE: begin
            if (w_win_vld) begin
               gnt_d   = NUM_REQ'(1) << w_win_idx;
               dat_d   = w_dat[w_win_idx];
               last_d  = w_win_idx;
               hit_d   = 1'b0;
               state_d = ff_empty_i ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A valid response in the last allowed cycle beats the timeout.
            if (ff_check_vld_i) begin
               hit_d   = ff_check_res_i;
               state_d = S_RESP;
            end else if (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
               hit_d   = 1'b0;
               terr_d  = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + TO_WIDTH'(1);
            end
         end
         S_RESP: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         hit_q   <= 1'b0;
         terr_q  <= 1'b0;
         cnt_q   <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         hit_q   <= hit_d;
         terr_q  <= terr_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         dat_q   <= dat_d;
      end
   end

   assign gnt_o          = gnt_q;
   assign done_o         = (state_q == S_RESP);
   assign hit_o          = hit_q;
   assign busy_o         = (state_q != S_IDLE);
   assign timeout_err_o  = terr_q;
   assign ff_check_req_o = (state_q == S_ISSUE);
   assign ff_check_dat_o = dat_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_check_arbiter.sv
// ============================================================================
// tb_fifo_check_arbiter : directed bench with a transaction-level reference
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fifo_check_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int TO = 8;
   localparam int TW = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req = '0;
   logic [NR*DW-1:0]  req_dat = '0;
   logic [NR-1:0]     gnt_o;
   logic              done_o, hit_o, busy_o, timeout_err_o;
   logic              ff_empty = 1'b0;
   logic              ff_check_req_o;
   logic [DW-1:0]     ff_check_dat_o;
   logic              ff_check_res = 1'b0;
   logic              ff_check_vld = 1'b0;

   fifo_check_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .TO_WIDTH(TW)
   ) dut (
      .clk(clk), .rst(rst), .req_i(req), .req_dat_i(req_dat),
      .gnt_o(gnt_o), .done_o(done_o), .hit_o(hit_o), .busy_o(busy_o),
      .timeout_err_o(timeout_err_o), .ff_empty_i(ff_empty),
      .ff_check_req_o(ff_check_req_o), .ff_check_dat_o(ff_check_dat_o),
      .ff_check_res_i(ff_check_res), .ff_check_vld_i(ff_check_vld)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // FIFO contents seen by the content-check responder
   logic [DW-1:0] present [3] = '{32'h0000_00AA, 32'h1111_0000, 32'h3333_3333};
   function automatic bit is_present(input logic [DW-1:0] d);
      foreach (present[i]) if (present[i] == d) return 1'b1;
      return 1'b0;
   endfunction

   // FIFO responder: answers vld_delay cycles after the issue cycle
   int vld_delay = 1;
   int since = -1;
   initial forever begin
      @(posedge clk); #1;
      if (rst) since = -1;
      else if (ff_check_req_o) since = 0;
      else if (since >= 0) since++;
      ff_check_vld = (since == vld_delay);
      ff_check_res = ff_check_vld && is_present(ff_check_dat_o);
   end

   // Reference: each operation is a record with its start and response cycle
   bit            op_v = 0, op_empty = 0, op_hit = 0, op_to = 0, terr_st = 0;
   int            op_s = 0, op_e = 0, op_w = 0, last = NR - 1;
   logic [DW-1:0] op_dat = '0;
   int            done_cyc[$];
   logic [NR-1:0] done_gnt[$];
   logic          done_hit[$];
   int            nreq = 0;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_gnt", gnt_o, 0);
         chk("rst_busy", busy_o, 0);
         chk("rst_done", done_o, 0);
         chk("rst_ffreq", ff_check_req_o, 0);
         chk("rst_terr", timeout_err_o, 0);
         chk("rst_dat", ff_check_dat_o, 0);
         op_v = 0; terr_st = 0; last = NR - 1;
      end else begin
         if (op_v && cyc > op_e) begin
            terr_st = terr_st | op_to;
            op_v = 0;
         end
         chk("gnt", gnt_o, op_v ? (64'd1 << op_w) : 64'd0);
         chk("busy", busy_o, op_v);
         chk("done", done_o, op_v && cyc == op_e);
         chk("ffreq", ff_check_req_o, op_v && !op_empty && cyc == op_s + 1);
         chk("terr", timeout_err_o, terr_st || (op_v && op_to && cyc == op_e));
         if (op_v) chk("ffdat", ff_check_dat_o, op_dat);
         if (op_v && cyc == op_e) chk("hit", hit_o, op_hit);
         if (!op_v && req != 0) begin
            for (int i = 0; i < NR; i++) begin
               int k;
               k = (last + 1 + i) % NR;
               if (!op_v && req[k]) begin
                  op_v = 1; op_w = k;
               end
            end
            last     = op_w;
            op_s     = cyc;
            op_dat   = req_dat[op_w*DW +: DW];
            op_empty = ff_empty;
            op_to    = !ff_empty && (vld_delay > TO);
            op_hit   = !ff_empty && (vld_delay <= TO) && is_present(op_dat);
            op_e     = ff_empty ? op_s + 1 : op_s + 2 + ((vld_delay < TO) ? vld_delay : TO);
         end
      end
      if (done_o) begin
         done_cyc.push_back(cyc);
         done_gnt.push_back(gnt_o);
         done_hit.push_back(hit_o);
      end
      if (ff_check_req_o) nreq++;
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_dones(input int target);
      int b = 0;
      while (done_cyc.size() < target && b < 60) begin tick(1); b++; end
      chk("done_count", done_cyc.size(), target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
      $fatal(1);
   end

   int c0, d0, n0;
   logic [NR-1:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic          exp_rrhit [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      tick(3); rst = 0; tick(2);

      // single requester, data present, answered in first WAIT cycle
      req_dat[0*DW +: DW] = 32'h0000_00AA; vld_delay = 1;
      n0 = nreq; d0 = done_cyc.size(); c0 = cyc; req = 4'b0001;
      wait_dones(d0 + 1); req = 0;
      chk("t1_lat", done_cyc[d0] - c0, 3);
      chk("t1_gnt", done_gnt[d0], 4'b0001);
      chk("t1_hit", done_hit[d0], 1);
      chk("t1_nreq", nreq - n0, 1);

      // round robin after reset with all requesters held
      rst = 1; tick(2); rst = 0; tick(1);
      req_dat = {32'h0000_4444, 32'h3333_3333, 32'h0000_2222, 32'h1111_0000};
      d0 = done_cyc.size(); c0 = cyc; req = 4'b1111;
      wait_dones(d0 + 5); req = 0;
      chk("t2_lat", done_cyc[d0] - c0, 3);
      for (int i = 0; i < 5; i++) begin
         chk("t2_gnt", done_gnt[d0+i], exp_order[i]);
         chk("t2_hit", done_hit[d0+i], exp_rrhit[i]);
         if (i > 0) chk("t2_space", done_cyc[d0+i] - done_cyc[d0+i-1], 4);
      end

      // empty FIFO short-circuits to a miss
      tick(1); ff_empty = 1;
      n0 = nreq; d0 = done_cyc.size(); c0 = cyc; req = 4'b0100;
      wait_dones(d0 + 1); req = 0; ff_empty = 0;
      chk("t3_lat", done_cyc[d0] - c0, 1);
      chk("t3_gnt", done_gnt[d0], 4'b0100);
      chk("t3_hit", done_hit[d0], 0);
      chk("t3_nreq", nreq - n0, 0);

      // timeout, then a normal check with sticky error kept
      tick(1); vld_delay = 100; req_dat[1*DW +: DW] = 32'h0000_00AA;
      n0 = nreq; d0 = done_cyc.size(); c0 = cyc; req = 4'b0010;
      wait_dones(d0 + 1); req = 0;
      chk("t4_lat", done_cyc[d0] - c0, 10);
      chk("t4_hit", done_hit[d0], 0);
      chk("t4_terr", timeout_err_o, 1);
      chk("t4_nreq", nreq - n0, 1);
      tick(1); vld_delay = 1;
      d0 = done_cyc.size(); c0 = cyc; req = 4'b0010;
      wait_dones(d0 + 1); req = 0;
      chk("t4b_lat", done_cyc[d0] - c0, 3);
      chk("t4b_hit", done_hit[d0], 1);
      chk("t4b_terr", timeout_err_o, 1);

      // vld in the final WAIT cycle wins over the timeout
      rst = 1; tick(2); rst = 0; tick(1);
      vld_delay = TO; req_dat[3*DW +: DW] = 32'h0000_00AA;
      d0 = done_cyc.size(); c0 = cyc; req = 4'b1000;
      wait_dones(d0 + 1); req = 0;
      chk("t5_lat", done_cyc[d0] - c0, 10);
      chk("t5_hit", done_hit[d0], 1);
      chk("t5_terr", timeout_err_o, 0);

      // asynchronous reset during WAIT
      tick(1); vld_delay = 100; req = 4'b0001;
      tick(5);
      chk("t6_busy_pre", busy_o, 1);
      d0 = done_cyc.size();
      #2 rst = 1;
      #1;
      chk("t6_gnt", gnt_o, 0);
      chk("t6_busy", busy_o, 0);
      chk("t6_ffreq", ff_check_req_o, 0);
      chk("t6_done", done_o, 0);
      tick(2); req = 4'b1001; vld_delay = 1; rst = 0;
      chk("t6_nodone", done_cyc.size(), d0);
      wait_dones(d0 + 2); req = 0;
      chk("t6_first", done_gnt[d0], 4'b0001);
      chk("t6_second", done_gnt[d0+1], 4'b1000);

      tick(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_check_arbiter.md
# fifo_check_arbiter

Shares the content-check port of the line-buffer FIFO between up to NUM_REQ requesters (e.g. sprite/overlay lookup clients in the VGA pipeline). It grants one requester at a time with round-robin priority and drives the FIFO's check request and data. It waits for the FIFO's check-valid, or a timeout, and returns a hit/miss result with a one-cycle done pulse to the granted requester. It short-circuits to a miss when the FIFO is empty.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_WIDTH, 32: check data width; must match FIFO
- TIMEOUT_CYCLES, 64: max cycles spent in WAIT before forced miss
- TO_WIDTH, 7: timeout counter width; must hold TIMEOUT_CYCLES

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester check request; level, held until done
- req_dat  in  NUM_REQ*DATA_WIDTH  flattened check data; requester k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- gnt  out  NUM_REQ  one-hot grant, valid from ISSUE through RESP (or RESP only on empty path)
- done  out  1  one-cycle pulse in RESP
- hit  out  1  result, valid when done=1; 1 = data present in FIFO
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky; set on any timeout, cleared only by rst
- ff_empty  in  1  FIFO empty flag
- ff_check_req  out  1  one-cycle check request pulse to FIFO
- ff_check_dat  out  DATA_WIDTH  check data, held stable from ISSUE until leaving WAIT
- ff_check_res  in  1  FIFO compare result
- ff_check_vld  in  1  FIFO check complete

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from registered state only.
- IDLE: if any req bit is set, the round-robin winner is chosen. Search starts at (last_gnt+1) mod NUM_REQ and moves upward with wrap. On the winner:
  - gnt is loaded one-hot.
  - ff_check_dat is latched from the winner's req_dat slice.
  - last_gnt is updated.
  - If ff_empty=1 that cycle: go to RESP with hit=0 (no FIFO access).
  - Else: go to ISSUE.
- ISSUE: ff_check_req=1 for exactly one cycle. Timeout counter is cleared. Go to WAIT. ff_check_vld is ignored in ISSUE.
- WAIT: counter increments each cycle.
  - If ff_check_vld=1: hit<=ff_check_res; go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: hit<=0, timeout_err<=1; go to RESP.
  - If vld and timeout occur in the same cycle, vld wins and timeout_err is not set.
- RESP: done=1 and gnt is still asserted. Then go to IDLE and clear gnt.
- Requester drop: if the granted requester drops req mid-operation, the operation still completes and done still pulses. The requester ignores the result.
- New requests arriving during a busy operation are not sampled until IDLE.
- Reset values:
  - state=IDLE, gnt=0, done=0, hit=0, busy=0, timeout_err=0.
  - ff_check_req=0, ff_check_dat=0, counter=0.
  - last_gnt=NUM_REQ-1, so requester 0 has first priority.
- Reset asserted mid-operation: the FSM aborts immediately to IDLE with no done pulse. The FIFO is reset by the same rst.
- All counter arithmetic is unsigned TO_WIDTH and never wraps, because it exits at TIMEOUT_CYCLES-1.

## Timing
- Normal path:
  - Cycle 0: req sampled in IDLE.
  - Cycle 1: ISSUE, ff_check_req=1.
  - Cycle 2 onward: WAIT.
  - done pulses the cycle after ff_check_vld is seen.
  - Minimum latency is req-to-done of 3 cycles (vld in the first WAIT cycle).
- Empty path: done in cycle 1; latency 1 cycle, no ff_check_req.
- Timeout path: done at cycle 2+TIMEOUT_CYCLES.
- Back-to-back: IDLE is re-entered after RESP, so the minimum spacing between grants is 4 cycles (2 on the empty path).
- ff_check_dat is stable from the ISSUE cycle until the RESP cycle inclusive.

## Test plan
- Single requester: req[0]=1, dat=0x0000_00AA present in FIFO, ff_check_vld/res=1 in the first WAIT cycle -> gnt=0001, one ff_check_req pulse, done+hit=1 at cycle 3, ff_check_dat=0xAA throughout.
- Round-robin: req=1111 held continuously, each check answered immediately -> grant order 0,1,2,3,0. Each done is spaced 4 cycles apart, gnt is never multi-hot.
- Empty short-circuit: ff_empty=1, req[2]=1 -> gnt=0100, done=1, hit=0 at cycle 1, ff_check_req never asserted.
- Timeout: TIMEOUT_CYCLES=8, ff_check_vld held 0 -> done with hit=0 at cycle 10, timeout_err=1 and stays 1. A subsequent normal check still works.
- Vld/timeout collision: ff_check_vld=1, res=1 in the final WAIT cycle -> hit=1, timeout_err stays 0.
- Async reset: rst asserted during WAIT, between clock edges -> all outputs 0 immediately, no done. After release, req[3] and req[0] both set -> req[0] granted first.
